// File: rtl/key_event_decoder.sv
// key_event_decoder: synchronises and debounces four push-buttons, turns each
// clean single-key press into a 2-bit key code on a valid/ready event port,
// rejects chords and bounces, and flags events dropped on overrun.
module key_event_decoder #(
    parameter int DEBOUNCE_CYC = 50,
    parameter bit KEY_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic [3:0] key_state,
    output logic       overrun
);

    localparam int              CNT_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]      REL_LEVEL = KEY_ACT_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        WAIT_REL  = 2'd2
    } state_e;

    // Binary index of a one-hot key pattern.
    function automatic logic [1:0] encode_key(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]       sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap_q, cap_d;
    logic             evt_valid_q, evt_valid_d;
    logic [1:0]       evt_code_q, evt_code_d;
    logic [3:0]       key_state_q, key_state_d;
    logic             overrun_q, overrun_d;

    logic [3:0]       p_s;
    logic             one_hot_s;
    logic             emit_s;

    // Pressed-key pattern from the synchronised inputs, plus one-hot test.
    always_comb begin
        p_s       = sync2_q ^ REL_LEVEL;
        one_hot_s = (p_s != 4'd0) && ((p_s & (p_s - 4'd1)) == 4'd0);
    end

    // Debounce state machine and event-port handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        key_state_d = key_state_q;
        overrun_d   = overrun_q;
        emit_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (one_hot_s) begin
                    cap_d   = p_s;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end else begin
                    state_d = IDLE;
                end
            end
            DEB_PRESS: begin
                if (p_s != cap_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    emit_s      = 1'b1;
                    cnt_d       = '0;
                    key_state_d = cap_q;
                    state_d     = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (p_s != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d       = '0;
                    key_state_d = 4'd0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d       = '0;
                key_state_d = 4'd0;
                state_d     = IDLE;
            end
        endcase

        // A new event only loads when the slot is free or being taken now.
        if (emit_s) begin
            if (evt_valid_q && !evt_ready) begin
                overrun_d = 1'b1;
            end else begin
                evt_valid_d = 1'b1;
                evt_code_d  = encode_key(cap_q);
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= REL_LEVEL;
            sync2_q     <= REL_LEVEL;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_q       <= 4'd0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 2'd0;
            key_state_q <= 4'd0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            key_state_q <= key_state_d;
            overrun_q   <= overrun_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign key_state = key_state_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed testbench for key_event_decoder (default parameters, active-low keys).
module tb_key_event_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [3:0] key_state;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    key_event_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .key_state (key_state),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Hold rst for n cycles with keys released, leave at a falling edge.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        key_in    = 4'hF;
        evt_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Index of the first rising edge after which evt_valid is 1, or -1.
    task automatic wait_valid(input int max_edges, output int idx);
        bit found;
        idx   = -1;
        found = 1'b0;
        for (int i = 0; i < max_edges; i++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                if (evt_valid) begin
                    idx   = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    // Count cycles with evt_valid high over a window.
    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (evt_valid) n++;
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        rst = 1'b1; key_in = 4'hF; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({evt_valid, evt_code, key_state, overrun} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%0d ks=%b ov=%b, want all 0",
                     evt_valid, evt_code, key_state, overrun);
        end
        rst = 1'b0;
        count_valid(200, n);
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_events: got %0d valid cycles, want 0", n);
        end
    endtask

    task automatic test_clean_press();
        int idx;
        do_reset(2);
        evt_ready = 1'b1;
        key_in    = 4'b1101;
        wait_valid(100, idx);
        n_checks++;
        if (idx !== 52) begin
            n_fail++;
            $display("FAIL press_latency: got edge %0d, want 52", idx);
        end
        n_checks++;
        if (evt_code !== 2'd1 || key_state !== 4'b0010) begin
            n_fail++;
            $display("FAIL press_code: got code=%0d ks=%b, want 1 0010", evt_code, key_state);
        end
        @(posedge clk); #1;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL press_pulse: got valid=%b, want 0", evt_valid);
        end
        @(negedge clk);
        key_in = 4'hF;
        repeat (60) @(negedge clk);
        n_checks++;
        if (key_state !== 4'd0) begin
            n_fail++;
            $display("FAIL release_state: got %b, want 0000", key_state);
        end
    endtask

    task automatic test_bounce();
        int idx, n;
        do_reset(2);
        evt_ready = 1'b1;
        key_in    = 4'b1110;
        for (int t = 0; t < 20; t++) begin
            repeat (10) @(negedge clk);
            key_in[0] = ~key_in[0];
        end
        // 20 toggles leave key0 pressed; that final toggle is edge reference.
        wait_valid(100, idx);
        n_checks++;
        if (idx !== 52) begin
            n_fail++;
            $display("FAIL bounce_latency: got edge %0d, want 52", idx);
        end
        n_checks++;
        if (evt_code !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce_code: got %0d, want 0", evt_code);
        end
        count_valid(100, n);
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL bounce_single: got %0d extra valid cycles, want 0", n);
        end
    endtask

    task automatic test_chord();
        int n;
        do_reset(2);
        evt_ready = 1'b1;
        key_in    = 4'b1100;
        count_valid(150, n);
        n_checks++;
        if (n !== 0 || key_state !== 4'd0) begin
            n_fail++;
            $display("FAIL chord: got %0d events ks=%b, want 0 0000", n, key_state);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        do_reset(2);
        key_in = 4'b1110;
        wait_valid(100, idx);
        n_checks++;
        if (idx !== 52 || evt_code !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_first: got edge %0d code %0d, want 52 0", idx, evt_code);
        end
        @(negedge clk);
        key_in = 4'hF;
        repeat (60) @(negedge clk);
        key_in = 4'b1101;
        repeat (52) @(posedge clk);
        #1;
        evt_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'd1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_same_edge: got v=%b c=%0d ov=%b, want 1 1 0",
                     evt_valid, evt_code, overrun);
        end
        @(posedge clk); #1;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_consume: got valid=%b, want 0", evt_valid);
        end
    endtask

    task automatic test_backpressure();
        int idx, n;
        do_reset(2);
        key_in = 4'b1011;
        wait_valid(100, idx);
        n_checks++;
        if (idx !== 52 || evt_code !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_first: got edge %0d code %0d, want 52 2", idx, evt_code);
        end
        @(negedge clk);
        key_in = 4'hF;
        repeat (60) @(negedge clk);
        key_in = 4'b0111;
        repeat (60) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'd2 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overrun: got v=%b c=%0d ov=%b, want 1 2 1",
                     evt_valid, evt_code, overrun);
        end
        n_checks++;
        if (key_state !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_key_state: got %b, want 1000", key_state);
        end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consume: got valid=%b, want 0", evt_valid);
        end
        key_in = 4'b0011;
        count_valid(100, n);
        n_checks++;
        if (n !== 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after: got %0d events ov=%b, want 0 1", n, overrun);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int idx, n;
        do_reset(2);
        evt_ready = 1'b1;
        key_in    = 4'b1101;
        count_valid(30, n);
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL mid_early: got %0d events, want 0", n);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({evt_valid, evt_code, key_state, overrun} !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got v=%b c=%0d ks=%b ov=%b, want all 0",
                     evt_valid, evt_code, key_state, overrun);
        end
        rst = 1'b0;
        wait_valid(100, idx);
        n_checks++;
        if (idx !== 52 || evt_code !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_latency: got edge %0d code %0d, want 52 1", idx, evt_code);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_in    = 4'hF;
        evt_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_chord();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
